// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: word RAM with fixed latency plus the 0xFFFF I/O word
// (switches on read, hex display register on write).
module slc3_mem_responder #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [15:0] SW,
    output logic [15:0] MDR_In,
    output logic        mem_ready,
    output logic        busy,
    output logic [15:0] HEX_Data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_addr;
    logic [15:0] r_data;
    logic        r_wr;
    logic [15:0] r_mdr_in;
    logic [15:0] r_hex;
    logic [15:0] r_mem [0:(2**ADDR_W)-1];

    logic        w_req;
    logic        w_commit;
    logic        w_io;
    logic        w_in_range;
    logic [16:0] w_addr_x;

    assign w_req      = rd_req | wr_req;
    assign w_commit   = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_io       = (r_addr == 16'hFFFF);
    assign w_addr_x   = {1'b0, r_addr};
    assign w_in_range = ((w_addr_x >> ADDR_W) == 17'd0);

    // The I/O word takes priority even if the RAM would cover 0xFFFF.
    always_ff @(posedge Clk) begin
        if (w_commit && r_wr && !w_io && w_in_range)
            r_mem[r_addr[ADDR_W-1:0]] <= r_data;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= 16'h0000;
            r_data   <= 16'h0000;
            r_wr     <= 1'b0;
            r_mdr_in <= 16'h0000;
            r_hex    <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr  <= MAR;
                        r_data  <= MDR;
                        r_wr    <= wr_req;
                        r_cnt   <= LAT_M1;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        if (r_wr) begin
                            if (w_io)
                                r_hex <= r_data;
                        end else if (w_io) begin
                            r_mdr_in <= SW;
                        end else if (w_in_range) begin
                            r_mdr_in <= r_mem[r_addr[ADDR_W-1:0]];
                        end else begin
                            r_mdr_in <= 16'h0000;
                        end
                        r_state <= ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                // HOLD keeps a still-asserted level request from being serviced twice.
                ACK:     r_state <= w_req ? HOLD : IDLE;
                HOLD:    r_state <= w_req ? HOLD : IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign MDR_In    = r_mdr_in;
    assign HEX_Data  = r_hex;
    assign mem_ready = (r_state == ACK);
    assign busy      = (r_state != IDLE);

endmodule

// File: doc/slc3_mem_responder.md
# slc3_mem_responder

Memory-side responder for the SLC-3 datapath. It serves the datapath's MAR/MDR read and write requests from an on-chip word RAM with a programmable fixed latency. It also decodes the memory-mapped I/O word at 0xFFFF to the board switches (read) and the hex display register (write). It returns read data on `MDR_In` and signals completion with a one-cycle `mem_ready` pulse that the ISDU waits on.

## Interface
Parameters:
- `ADDR_W`, 10: RAM address bits; RAM depth = 2^ADDR_W words of 16 bits.
- `LAT`, 2: cycles from request acceptance to `mem_ready`; legal range 1..15.

Ports:
- `Clk` in 1: single clock; all state changes on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `MAR` in 16: request address, sampled at acceptance.
- `MDR` in 16: write data, sampled at acceptance.
- `rd_req` in 1: read request, level; held until `mem_ready` is seen.
- `wr_req` in 1: write request, level; held until `mem_ready` is seen.
- `SW` in 16: switch value returned for reads of 0xFFFF.
- `MDR_In` out 16: read data to the datapath MDR mux; holds its value between reads.
- `mem_ready` out 1: one-cycle completion pulse.
- `busy` out 1: high from acceptance until the FSM returns to IDLE.
- `HEX_Data` out 16: hex display register, written via address 0xFFFF.

## Operation
- The FSM has four states: IDLE, WAIT, ACK and HOLD.
- **IDLE**
  - If `rd_req | wr_req` is high at an edge, the block latches `MAR`, `MDR` and op into internal registers, loads the counter with LAT-1 and goes to WAIT.
  - If `rd_req` and `wr_req` are both high, the request is a write; the read is dropped.
- **WAIT**
  - The counter decrements each edge. When it is 0, the block commits the operation at that edge and goes to ACK.
  - With LAT=1, the counter is loaded with 0, so the commit happens on the first WAIT edge.
- **Commit**
  - Read from 0xFFFF: `MDR_In` ← `SW`, as sampled at the commit edge.
  - Read from an address below 2^ADDR_W: `MDR_In` ← RAM[addr].
  - Read from any other address: `MDR_In` ← 0x0000.
  - Write to 0xFFFF: `HEX_Data` ← data; RAM is unchanged.
  - Write to an address below 2^ADDR_W: RAM[addr] ← data.
  - Write to any other address: ignored, but still acknowledged.
  - Writes never change `MDR_In`.
- **ACK**
  - `mem_ready`=1 for exactly this cycle.
  - Next state is HOLD if `rd_req | wr_req` is still high, otherwise IDLE.
- **HOLD**
  - Waits for both requests low, then goes to IDLE.
  - This guarantees a held level request is serviced exactly once.
- `MAR`/`MDR` changes after acceptance have no effect on the current operation.
- RAM contents are not cleared by reset and power up undefined. The bench must initialise by writes.

## Timing
- Reset values: `MDR_In`=0x0000, `mem_ready`=0, `busy`=0, `HEX_Data`=0x0000, state IDLE, counter 0.
- Reset asserted mid-operation returns the FSM to IDLE immediately, and the pending op is abandoned.
  - A write not yet committed leaves RAM and `HEX_Data` untouched. `HEX_Data` is 0 anyway, since it is reset.
  - No `mem_ready` pulse is produced.
- Acceptance at edge k → commit and `mem_ready` rise at edge k+LAT → `mem_ready` falls at edge k+LAT+1.
- `MDR_In` is valid on the same cycle `mem_ready` is high.
- `busy` rises at edge k and falls on entry to IDLE.
- Minimum back-to-back spacing, with the request dropped during the ACK cycle: the next acceptance can occur at edge k+LAT+2.
- A request raised during WAIT, ACK or HOLD is not queued. It is seen only once IDLE is reached.

## Test plan
- **Basic write then read** (LAT=2): write 0x1234 to 0x0010, accepted at edge k → `mem_ready` high only in cycle k+2. Read 0x0010 → `MDR_In`=0x1234 while `mem_ready`=1.
- **I/O mapping**: with SW=0xBEEF, read 0xFFFF → `MDR_In`=0xBEEF. Write 0x00A5 to 0xFFFF → `HEX_Data`=0x00A5, and a subsequent read of 0x03FF is unchanged.
- **Held request**: `rd_req` held high for 12 cycles → exactly one `mem_ready` pulse. `busy` stays high until `rd_req` falls, then IDLE.
- **Simultaneous request**: `rd_req`=`wr_req`=1, MAR=0x0020, MDR=0x5A5A → RAM[0x20]=0x5A5A and `MDR_In` keeps its prior value.
- **Out of range** (ADDR_W=10): write 0xFFFF to 0x0400 → acknowledged after LAT cycles. Read 0x0400 → `MDR_In`=0x0000, and RAM[0x000] is unchanged.
- **Reset mid-op**: write 0xCAFE to 0x0030 with LAT=4, assert `Reset` low during WAIT → no `mem_ready`, RAM[0x30] retains its prior value, and all outputs read their reset values.
